pc_fetch_rv32i: RTL and testbench

Instruction-fetch stage of the RV32I core. It sits directly upstream of instr_rom_rv32i.
- Holds the program counter and drives ADDR into the combinational ROM.
- Captures the returned INSTR into an IF/ID pipeline register.
- Handles stall from decode, control-flow redirect from execute, and misaligned-target traps.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/pc_next_mux.sv | 32 +++
 rtl/pc_fetch_rv32i.sv | 112 +++++++++++
 tb/tb_pc_fetch_rv32i.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end constants and the IF/ID pipeline bundle.
// Imported by the fetch stage and its next-PC selector.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0]    TRAP_VEC_DEFAULT = 32'h0000_0100;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

    // BUBBLE: IF/ID holds the NOP filler; VALID: IF/ID holds a fetched instruction.
    typedef enum logic {
        FETCH_BUBBLE = 1'b0,
        FETCH_VALID  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage: redirect beats stall beats advance,
// and a redirect to a non-word-aligned target is diverted to the trap vector.
module pc_next_mux
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign,
    output logic            flush,
    output logic            advance
);

    always_comb begin
        misalign = redirect_valid && is_misaligned(redirect_target[1:0]);
        flush    = redirect_valid;
        advance  = !redirect_valid && !stall;
        next_pc  = pc;
        if (misalign) begin
            next_pc = TRAP_VEC;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (!stall) begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/pc_fetch_rv32i.sv
// RV32I instruction-fetch stage: PC register driving a combinational ROM,
// IF/ID capture register, accepted-instruction counter and misalign trap pulse.
module pc_fetch_rv32i #(
    parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VEC  = rv32i_pkg::TRAP_VEC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] ADDR,
    input  logic [31:0] INSTR,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        misalign_exc,
    output logic [31:0] fetch_count
);

    import rv32i_pkg::XLEN;
    import rv32i_pkg::if_id_t;
    import rv32i_pkg::fetch_state_e;
    import rv32i_pkg::FETCH_BUBBLE;
    import rv32i_pkg::FETCH_VALID;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc4_q;
    logic [31:0]     id_instr_q;
    logic            misalign_q;
    logic [31:0]     fetch_count_q;

    logic [XLEN-1:0] next_pc;
    logic            misalign;
    logic            flush;
    logic            advance;
    if_id_t          if_id;

    pc_next_mux #(
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_next_mux (
        .pc              (pc_q),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .misalign        (misalign),
        .flush           (flush),
        .advance         (advance)
    );

    // if_id_valid is the FSM state itself, so BUBBLE/VALID can never disagree with it.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FETCH_BUBBLE;
        end else if (advance) begin
            state_d = FETCH_VALID;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH_BUBBLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= RESET_PC;
            id_pc4_q      <= RESET_PC + 32'd4;
            id_instr_q    <= NOP_INSTR;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q       <= next_pc;
            misalign_q <= misalign;
            if (flush) begin
                // Flush replaces only the instruction; pc/pc4 keep their last values.
                id_instr_q <= NOP_INSTR;
            end else if (advance) begin
                id_pc_q       <= pc_q;
                id_pc4_q      <= pc_q + 32'd4;
                id_instr_q    <= INSTR;
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        if_id.valid = (state_q == FETCH_VALID);
        if_id.pc    = id_pc_q;
        if_id.pc4   = id_pc4_q;
        if_id.instr = id_instr_q;
    end

    assign ADDR         = pc_q;
    assign if_id_valid  = if_id.valid;
    assign if_id_pc     = if_id.pc;
    assign if_id_pc4    = if_id.pc4;
    assign if_id_instr  = if_id.instr;
    assign misalign_exc = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_rv32i.sv
// Bench for pc_fetch_rv32i: directed plan steps then randomized traffic,
// every cycle compared against a rule-level fetch model.
module tb_pc_fetch_rv32i;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] ADDR;
    logic [31:0] INSTR;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        misalign_exc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] salt;

    logic        m_valid, m_exc;
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;

    pc_fetch_rv32i #(
        .RESET_PC  (RESET_PC),
        .TRAP_VEC  (TRAP_VEC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ADDR            (ADDR),
        .INSTR           (INSTR),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_instr     (if_id_instr),
        .misalign_exc    (misalign_exc),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    assign INSTR = rom_word(ADDR);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ADDR"},         ADDR,                 m_pc);
        chk({tag, ".if_id_valid"},  {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".if_id_pc"},     if_id_pc,             m_ifpc);
        chk({tag, ".if_id_pc4"},    if_id_pc4,            m_ifpc4);
        chk({tag, ".if_id_instr"},  if_id_instr,          m_instr);
        chk({tag, ".misalign_exc"}, {31'd0, misalign_exc}, {31'd0, m_exc});
        chk({tag, ".fetch_count"},  fetch_count,          m_cnt);
    endtask

    // Apply inputs for one cycle, update the model from the priority rules, compare after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic rv,
                        input logic [31:0] tgt);
        reset           = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        if (r) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_ifpc = RESET_PC; m_ifpc4 = RESET_PC + 4;
            m_instr = NOP_INSTR; m_exc = 1'b0; m_cnt = 0;
        end else if (rv && (tgt % 4 != 0)) begin
            m_pc = TRAP_VEC; m_valid = 1'b0; m_instr = NOP_INSTR; m_exc = 1'b1;
        end else if (rv) begin
            m_pc = tgt; m_valid = 1'b0; m_instr = NOP_INSTR; m_exc = 1'b0;
        end else if (s) begin
            m_exc = 1'b0;
        end else begin
            m_valid = 1'b1; m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = rom_word(m_pc);
            m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_exc = 1'b0;
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        salt            = $urandom;
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        step("reset0", 1'b1, 1'b0, 1'b0, 32'h0);
        step("reset1", 1'b1, 1'b0, 1'b0, 32'h0);
        chk("reset_addr",  ADDR,        RESET_PC);
        chk("reset_instr", if_id_instr, NOP_INSTR);

        for (int unsigned i = 0; i < 4; i++) step("adv", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("adv_addr16", ADDR,        32'h10);
        chk("adv_ifpc12", if_id_pc,    32'h0C);
        chk("adv_count4", fetch_count, 32'd4);

        step("redir8", 1'b0, 1'b0, 1'b1, 32'h8);
        step("adv8",   1'b0, 1'b0, 1'b0, 32'h0);
        step("adv12",  1'b0, 1'b0, 1'b0, 32'h0);
        step("redir8b", 1'b0, 1'b0, 1'b1, 32'h4);
        step("adv4",   1'b0, 1'b0, 1'b0, 32'h0);
        for (int unsigned i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_addr8",  ADDR,     32'h8);
        chk("stall_ifpc4",  if_id_pc, 32'h4);
        step("unstall", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("unstall_ifpc8", if_id_pc, 32'h8);

        step("redir40_stall", 1'b0, 1'b1, 1'b1, 32'h40);
        chk("redir40_addr", ADDR, 32'h40);
        step("after40", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("after40_ifpc", if_id_pc, 32'h40);

        step("mis42", 1'b0, 1'b0, 1'b1, 32'h42);
        chk("mis42_addr", ADDR, TRAP_VEC);
        chk("mis42_exc",  {31'd0, misalign_exc}, 32'd1);
        step("mis42_next", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("mis42_pulse", {31'd0, misalign_exc}, 32'd0);

        step("redir_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", ADDR,      32'h0);
        chk("wrap_ifpc", if_id_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4",  if_id_pc4, 32'h0);

        step("rst_mis", 1'b1, 1'b0, 1'b1, 32'h42);
        chk("rst_mis_exc", {31'd0, misalign_exc}, 32'd0);
        chk("rst_mis_cnt", fetch_count, 32'd0);

        for (int unsigned i = 0; i < 400; i++) begin
            logic        r, s, rv;
            logic [31:0] tgt;
            int unsigned sel;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 30);
            rv  = ($urandom_range(0, 99) < 12);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       tgt = {$urandom, 2'b00} >> 0;
                1:       tgt = $urandom | 32'h1;
                2:       tgt = 32'hFFFF_FFF8 + 32'h4 * $urandom_range(0, 1);
                default: tgt = 32'h4 * $urandom_range(0, 63);
            endcase
            if (sel == 0) tgt[1:0] = 2'b00;
            step("rand", r, s, rv, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
